// File: rtl/iir_seq_ctrl_if.sv
// Sequencer handshake bundle for the time-multiplexed IIR datapath.
//   din_vld   : one-cycle sample strobe
//   coe_ctrl  : requested coefficient bank
//   ovr_clr   : clears the sticky overrun flag
//   busy      : sequence in progress (MAC or WB)
//   coe_addr  : coefficient ROM address {bank, stage, tap}
//   tap_sel   : MAC operand select
//   stage_sel : stage whose delay line is read/written
//   mac_clr   : accumulator loads the product instead of adding
//   mac_en    : MAC product valid
//   st_wr     : stage result write-back strobe
//   dout_vld  : one-cycle pulse, output sample valid
//   overrun   : sticky, strobe arrived while busy
interface iir_seq_ctrl_if #(
  parameter int SW = 2,
  parameter int TW = 3,
  parameter int BW = 3
);
  logic              din_vld;
  logic [BW-1:0]     coe_ctrl;
  logic              ovr_clr;
  logic              busy;
  logic [BW+SW+TW-1:0] coe_addr;
  logic [TW-1:0]     tap_sel;
  logic [SW-1:0]     stage_sel;
  logic              mac_clr;
  logic              mac_en;
  logic              st_wr;
  logic              dout_vld;
  logic              overrun;

  modport master (
    output din_vld, coe_ctrl, ovr_clr,
    input  busy, coe_addr, tap_sel, stage_sel, mac_clr, mac_en, st_wr,
           dout_vld, overrun
  );

  modport slave (
    input  din_vld, coe_ctrl, ovr_clr,
    output busy, coe_addr, tap_sel, stage_sel, mac_clr, mac_en, st_wr,
           dout_vld, overrun
  );
endinterface

// File: rtl/iir_seq_ctrl.sv
// Sequencer for a cascade of biquad stages sharing one MAC. Each accepted
// sample strobe walks every stage and tap in order, then flags the output.
// Ports: clk, rst (async, active-high), bus (iir_seq_ctrl_if.slave).
//
// state | meaning
// IDLE  | waiting for a sample strobe
// MAC   | one product per cycle for the current stage/tap
// WB    | write the stage result back to its delay line
// DONE  | output sample valid; may restart on a coincident strobe
module iir_seq_ctrl #(
  parameter int STAGES = 3,
  parameter int TAPS   = 5,
  parameter int BANKS  = 6,
  parameter int SW     = 2,
  parameter int TW     = 3,
  parameter int BW     = 3
) (
  input logic          clk,
  input logic          rst,
  iir_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
  localparam logic [BW:0]   BANKS_L    = (BW+1)'(BANKS);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [BW-1:0] bank_q, bank_d;
  logic          overrun_q, overrun_d;

  logic busy_w;
  logic start_w;
  logic ovr_evt_w;

  assign busy_w    = (state_q == S_MAC) || (state_q == S_WB);
  // DONE accepts a strobe exactly like IDLE; only MAC/WB count as busy.
  assign start_w   = bus.din_vld && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign ovr_evt_w = bus.din_vld && busy_w;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    tap_d     = tap_q;
    bank_d    = bank_q;
    overrun_d = overrun_q;

    case (state_q)
      S_MAC: begin
        if (tap_q == TAP_LAST) begin
          state_d = S_WB;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WB: begin
        if (stage_q == STAGE_LAST) begin
          state_d = S_DONE;
          stage_d = '0;
        end else begin
          state_d = S_MAC;
          stage_d = stage_q + 1'b1;
          tap_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_w) begin
      state_d = S_MAC;
      stage_d = '0;
      tap_d   = '0;
      // Reserved bank codes fall back to bank 0.
      bank_d  = ({1'b0, bus.coe_ctrl} < BANKS_L) ? bus.coe_ctrl : '0;
    end

    // Set wins over clear.
    if (ovr_evt_w)        overrun_d = 1'b1;
    else if (bus.ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      tap_q     <= '0;
      bank_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      tap_q     <= tap_d;
      bank_q    <= bank_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode registered state only; address/selects are zero outside
  // the states that use them so the ROM and MAC see a quiet bus when idle.
  always_comb begin
    bus.busy      = busy_w;
    bus.coe_addr  = '0;
    bus.tap_sel   = '0;
    bus.stage_sel = '0;
    bus.mac_clr   = 1'b0;
    bus.mac_en    = 1'b0;
    bus.st_wr     = 1'b0;
    bus.dout_vld  = (state_q == S_DONE);
    bus.overrun   = overrun_q;
    if (state_q == S_MAC) begin
      bus.coe_addr  = {bank_q, stage_q, tap_q};
      bus.tap_sel   = tap_q;
      bus.stage_sel = stage_q;
      bus.mac_clr   = (tap_q == '0);
      bus.mac_en    = 1'b1;
    end
    if (state_q == S_WB) begin
      bus.stage_sel = stage_q;
      bus.st_wr     = 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_seq_ctrl.sv
module tb_iir_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  iir_seq_ctrl_if #(.SW(2), .TW(3), .BW(3)) bus ();

  iir_seq_ctrl #(.STAGES(3), .TAPS(5), .BANKS(6), .SW(2), .TW(3), .BW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // {busy, coe_addr[7:0], tap_sel[2:0], stage_sel[1:0], mac_clr, mac_en, st_wr, dout_vld}
  logic [17:0] obs;
  logic [17:0] exp_v;
  assign obs = {bus.busy, bus.coe_addr, bus.tap_sel, bus.stage_sel,
                bus.mac_clr, bus.mac_en, bus.st_wr, bus.dout_vld};

  // Expected outputs in cycle c after the accepting edge (c=0 or c>19: idle).
  // Each stage is 5 MAC cycles then one WB cycle; DONE in cycle 19.
  function automatic logic [17:0] exp_out(input logic [2:0] bank, input int c);
    logic [17:0] v;
    int idx, s, p;
    v = '0;
    if (c == 19) begin
      v[0] = 1'b1;
    end else if (c >= 1 && c <= 18) begin
      idx = c - 1;
      s = idx / 6;
      p = idx % 6;
      v[17] = 1'b1;
      if (p < 5) begin
        v[16:9] = {bank, s[1:0], p[2:0]};
        v[8:6]  = p[2:0];
        v[5:4]  = s[1:0];
        v[3]    = (p == 0);
        v[2]    = 1'b1;
      end else begin
        v[5:4] = s[1:0];
        v[1]   = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic test_reset();
    bus.din_vld = 1'b0; bus.coe_ctrl = '0; bus.ovr_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, 18'h0); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs, 18'h0); end
  endtask

  task automatic test_basic();
    bus.coe_ctrl = 3'd3; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      exp_v = exp_out(3'd3, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL basic c=%0d: got %h want %h", c, obs, exp_v); end
      if (c < 21) @(negedge clk);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_overrun();
    bus.coe_ctrl = 3'd3; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd3, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL overrun_seq c=%0d: got %h want %h", c, obs, exp_v); end
      n_checks++;
      if (bus.overrun !== (c >= 6)) begin
        n_fail++; $display("FAIL overrun_flag c=%0d: got %b want %b", c, bus.overrun, (c >= 6));
      end
      bus.din_vld = (c == 5);
      if (c < 20) @(negedge clk);
    end
    bus.din_vld = 1'b0;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
    // Clear coincident with a fresh overrun event.
    bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd3, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL overrun_coinc_seq c=%0d: got %h want %h", c, obs, exp_v); end
      bus.din_vld = (c == 3);
      bus.ovr_clr = (c == 3);
      if (c < 20) @(negedge clk);
    end
    n_checks++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set_wins: got %b want 1", bus.overrun); end
    bus.din_vld = 1'b0;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear2: got %b want 0", bus.overrun); end
  endtask

  task automatic test_bank_switch();
    bus.coe_ctrl = 3'd3; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd3, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bank_hold c=%0d: got %h want %h", c, obs, exp_v); end
      if (c == 7) bus.coe_ctrl = 3'd5;
      if (c < 20) @(negedge clk);
    end
    bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd5, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bank5 c=%0d: got %h want %h", c, obs, exp_v); end
      if (c < 20) @(negedge clk);
    end
  endtask

  task automatic test_reserved_bank();
    bus.coe_ctrl = 3'd7; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd0, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reserved c=%0d: got %h want %h", c, obs, exp_v); end
      if (c < 20) @(negedge clk);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reserved_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    bus.coe_ctrl = 3'd2; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      exp_v = exp_out(3'd2, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_first c=%0d: got %h want %h", c, obs, exp_v); end
      if (c == 19) bus.din_vld = 1'b1;
      @(negedge clk);
    end
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd2, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_second c=%0d: got %h want %h", c, obs, exp_v); end
      if (c < 20) @(negedge clk);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_async_reset();
    bus.coe_ctrl = 3'd4; bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      exp_v = exp_out(3'd4, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL arst_pre c=%0d: got %h want %h", c, obs, exp_v); end
      bus.din_vld = (c == 3);
      if (c < 14) @(negedge clk);
    end
    n_checks++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL arst_pre_overrun: got %b want 1", bus.overrun); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL arst_immediate: got %h want %h", obs, 18'h0); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL arst_overrun: got %b want 0", bus.overrun); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 18'h0) begin n_fail++; $display("FAIL arst_quiet c=%0d: got %h want %h", c, obs, 18'h0); end
    end
    bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_v = exp_out(3'd4, c);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL arst_post c=%0d: got %h want %h", c, obs, exp_v); end
      if (c < 20) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_bank_switch();
    test_reserved_bank();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
